sim_step_scheduler: RTL and testbench
=====================================

// Module: sim_step_scheduler
// PURPOSE
//  Frame-synchronous sequencer for the gravity-sim physics FSM and its shared body regfile.
//  Turns VGA vsync into a one-cycle FSM start pulse and waits for completion.
//  Applies pause (space) and single-step keys, and grants the host exclusive regfile access between steps.
//  Sits beside the Avalon regfile; drives the FSM start input; host_gnt gates CPU regfile writes.
// PARAMETERS
//  SPACE_CODE      8'd44      keycode toggling pause
//  STEP_CODE       8'd22      keycode requesting one step while paused
//  FRAMES_PER_STEP 1          vsync ticks per physics step (>=1)
//  TIMEOUT_CYCLES  1_000_000  max cycles in RUN before abort (>=2)
// PORTS
//  CLK            in   1   system clock, 50 MHz
//  RESET          in   1   synchronous, active-high reset
//  VGA_VS         in   1   VGA vsync, active low, asynchronous to CLK
//  keycode        in   8   current keyboard keycode, 0 = none
//  fsm_done       in   1   physics FSM done level
//  host_req       in   1   host wants regfile access (level)
//  fsm_start      out  1   one-cycle start pulse to FSM
//  host_gnt       out  1   host owns regfile
//  paused         out  1   pause state
//  busy           out  1   step in flight (START or RUN)
//  step_count     out  32  completed steps
//  overrun_count  out  16  dropped steps, saturating
//  timeout_err    out  1   sticky: a step timed out
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; frame counter, key history, sp_pend, timer = 0. RESET wins over every event.
//  RESET mid-step: next cycle is IDLE with outputs 0; a late fsm_done is ignored.
//  Vsync: 2-flop sync, then falling-edge detect -> frame_tick, 1 cycle, 3 CLK after VS falls.
//  Divider: frame_cnt counts frame_tick 0..FRAMES_PER_STEP-1 and wraps; step_due = tick & cnt==max.
//  The divider runs even while paused.
//  Keys: key_q holds the previous keycode. X_edge = (keycode==X_CODE) & (key_q!=X_CODE); holding a key = one edge.
//  Space edge toggles paused. Step edge while paused sets sp_pend; ignored when not paused.
//  sp_pend clears on unpause or when a step launches.
//  Decisions use register values from before the edge; a same-cycle space edge affects the next cycle only.
//  FSM states:
//   IDLE : host_req -> HOST (host has priority);
//          else step_due & (!paused | sp_pend) -> START.
//   START: fsm_start=1 for exactly this cycle; timer=0; -> RUN.
//   RUN  : done_rise = fsm_done & !done_q (done_q registered every cycle).
//          done_rise -> IDLE and step_count+1 (wraps at 2^32).
//          Else timer==TIMEOUT_CYCLES-1 -> IDLE, timeout_err<=1, step_count unchanged.
//          Else timer+1.
//   HOST : stays while host_req; -> IDLE when host_req low.
//          An IDLE step_due in that same cycle is not taken (next tick).
//  Outputs: host_gnt = (state==HOST); busy = (state in START,RUN); both decoded from registered state, no latency.
//  step_due in START/RUN/HOST: step dropped (never queued); overrun_count+1, held at 16'hFFFF.
//   Also counted when paused.
//  Pause during RUN: the current step completes normally; no new launches.
//  timeout_err clears only on RESET.
// TESTING
//  1 Free run, FPS=1: 3 VS falls, done rises 10 cyc after each start -> 3 single-cycle fsm_start, step_count=3.
//  2 keycode 0->44 held 100 cyc->0 -> paused=1 once; 2 VS falls -> no start, overrun_count=2;
//    keycode 22 pulse -> exactly 1 start at next tick.
//  3 host_req=1 in IDLE -> host_gnt=1 next cycle; VS fall in HOST -> no start, overrun+1;
//    host_req=0 -> host_gnt=0 next cycle.
//  4 TIMEOUT_CYCLES=64, done held low -> timeout_err=1 and IDLE 64 cyc after RUN entry;
//    step_count unchanged; next tick launches.
//  5 fsm_done stuck high from prior step -> RUN waits for a fresh rise; VS fall during RUN -> overrun+1, one start only.
//  6 RESET pulse during RUN, then done rises -> all outputs 0, step_count stays 0.

Source files
------------

// File: rtl/sim_step_scheduler_if.sv
// sim_step_scheduler_if: video, keyboard, physics-FSM and host handshake signals of the step scheduler.
interface sim_step_scheduler_if;
  logic        VGA_VS;
  logic [7:0]  keycode;
  logic        fsm_done;
  logic        host_req;
  logic        fsm_start;
  logic        host_gnt;
  logic        paused;
  logic        busy;
  logic [31:0] step_count;
  logic [15:0] overrun_count;
  logic        timeout_err;
  modport master (
    output VGA_VS, keycode, fsm_done, host_req,
    input  fsm_start, host_gnt, paused, busy, step_count, overrun_count, timeout_err
  );
  modport slave (
    input  VGA_VS, keycode, fsm_done, host_req,
    output fsm_start, host_gnt, paused, busy, step_count, overrun_count, timeout_err
  );
endinterface

// File: rtl/sim_step_scheduler.sv
// sim_step_scheduler: vsync-paced physics step launcher with pause/step keys and host regfile arbitration.
module sim_step_scheduler #(
  parameter logic [7:0] SPACE_CODE      = 8'd44,
  parameter logic [7:0] STEP_CODE       = 8'd22,
  parameter int         FRAMES_PER_STEP = 1,
  parameter int         TIMEOUT_CYCLES  = 1_000_000
) (
  input logic CLK,
  input logic RESET,
  sim_step_scheduler_if.slave bus
);
  localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2, S_HOST = 2'd3;
  logic [1:0]    state;
  logic          vs_s1, vs_s2, vs_q, frame_tick;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    key_q;
  logic          done_q, paused_q, sp_pend, timeout_q;
  logic [TW-1:0] timer;
  logic [31:0]   step_cnt;
  logic [15:0]   ovr_cnt;
  logic          step_due, space_edge, step_edge, launch, done_rise, tmo;
  always_comb begin
    step_due   = frame_tick && frame_cnt == FW'(FRAMES_PER_STEP - 1);
    space_edge = bus.keycode == SPACE_CODE && key_q != SPACE_CODE;
    step_edge  = bus.keycode == STEP_CODE && key_q != STEP_CODE;
    launch     = state == S_IDLE && !bus.host_req && step_due && (!paused_q || sp_pend);
    done_rise  = bus.fsm_done && !done_q;
    tmo        = timer == TW'(TIMEOUT_CYCLES - 1);
  end
  assign bus.fsm_start     = state == S_START;
  assign bus.host_gnt      = state == S_HOST;
  assign bus.busy          = state == S_START || state == S_RUN;
  assign bus.paused        = paused_q;
  assign bus.step_count    = step_cnt;
  assign bus.overrun_count = ovr_cnt;
  assign bus.timeout_err   = timeout_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      key_q      <= '0;
      done_q     <= 1'b0;
      paused_q   <= 1'b0;
      sp_pend    <= 1'b0;
      timeout_q  <= 1'b0;
      timer      <= '0;
      step_cnt   <= '0;
      ovr_cnt    <= '0;
    end else begin
      vs_s1      <= bus.VGA_VS;
      vs_s2      <= vs_s1;
      vs_q       <= vs_s2;
      frame_tick <= vs_q && !vs_s2;
      if (frame_tick)
        frame_cnt <= frame_cnt == FW'(FRAMES_PER_STEP - 1) ? '0 : frame_cnt + 1'b1;
      key_q  <= bus.keycode;
      done_q <= bus.fsm_done;
      if (space_edge)
        paused_q <= !paused_q;
      // a pending single step is consumed by its launch or discarded on unpause
      sp_pend <= (launch || (space_edge && paused_q)) ? 1'b0 :
                 (step_edge && paused_q) ? 1'b1 : sp_pend;
      if (step_due && !launch && ovr_cnt != 16'hFFFF)
        ovr_cnt <= ovr_cnt + 1'b1;
      case (state)
        S_IDLE: state <= bus.host_req ? S_HOST : launch ? S_START : S_IDLE;
        S_START: begin
          timer <= '0;
          state <= S_RUN;
        end
        S_RUN:
          if (done_rise) begin
            state    <= S_IDLE;
            step_cnt <= step_cnt + 1'b1;
          end else if (tmo) begin
            state     <= S_IDLE;
            timeout_q <= 1'b1;
          end else
            timer <= timer + 1'b1;
        default: state <= bus.host_req ? S_HOST : S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sim_step_scheduler.sv
// tb_sim_step_scheduler: directed scenario tests of the step scheduler with hand-computed expectations.
module tb_sim_step_scheduler;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int total = 0;
  int bad = 0;
  int starts = 0;
  int multi = 0;
  logic start_q = 1'b0;
  int exp_steps = 0;
  int exp_ovr = 0;
  sim_step_scheduler_if bus();
  sim_step_scheduler #(.TIMEOUT_CYCLES(64)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (bus.fsm_start) starts <= starts + 1;
    if (bus.fsm_start && start_q) multi <= multi + 1;
    start_q <= bus.fsm_start;
  end
  task automatic vs_fall;
    bus.VGA_VS = 1'b0;
    @(negedge CLK);
    bus.VGA_VS = 1'b1;
  endtask
  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.fsm_start) begin
        got = 1'b1;
        break;
      end
    end
  endtask
  task automatic finish_step(input int dly);
    repeat (dly) @(negedge CLK);
    bus.fsm_done = 1'b1;
    repeat (2) @(negedge CLK);
    bus.fsm_done = 1'b0;
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({bus.fsm_start, bus.host_gnt, bus.paused, bus.busy, bus.timeout_err, bus.step_count, bus.overrun_count} !== 53'd0) begin
      bad++;
      $display("FAIL reset_outputs: got st=%0b gnt=%0b p=%0b busy=%0b to=%0b steps=%0d ovr=%0d want all 0",
        bus.fsm_start, bus.host_gnt, bus.paused, bus.busy, bus.timeout_err, bus.step_count, bus.overrun_count);
    end
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (bus.busy !== 1'b0 || bus.fsm_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%0b start=%0b want 0 0", bus.busy, bus.fsm_start);
    end
  endtask
  task automatic test_free_run;
    bit got;
    int s0;
    int m0;
    s0 = starts;
    m0 = multi;
    for (int k = 0; k < 3; k++) begin
      vs_fall();
      wait_start(got);
      total++;
      if (got !== 1'b1) begin
        bad++;
        $display("FAIL free_run_start%0d: got %0b want 1", k, got);
      end
      finish_step(10);
      exp_steps++;
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL free_run_idle%0d: got busy=%0b want 0", k, bus.busy);
      end
    end
    repeat (2) @(negedge CLK);
    total++;
    if (bus.step_count !== 32'(exp_steps)) begin
      bad++;
      $display("FAIL free_run_steps: got %0d want %0d", bus.step_count, exp_steps);
    end
    total++;
    if (starts - s0 !== 3 || multi !== m0) begin
      bad++;
      $display("FAIL free_run_pulses: got starts=%0d multi=%0d want 3 0", starts - s0, multi - m0);
    end
  endtask
  task automatic test_pause_step;
    bit got;
    int s0;
    bus.keycode = 8'd44;
    repeat (100) @(negedge CLK);
    bus.keycode = 8'd0;
    @(negedge CLK);
    total++;
    if (bus.paused !== 1'b1) begin
      bad++;
      $display("FAIL pause_on: got %0b want 1", bus.paused);
    end
    s0 = starts;
    for (int k = 0; k < 2; k++) begin
      vs_fall();
      repeat (8) @(negedge CLK);
    end
    exp_ovr += 2;
    total++;
    if (starts !== s0 || bus.overrun_count !== 16'(exp_ovr)) begin
      bad++;
      $display("FAIL pause_drop: got starts=%0d ovr=%0d want 0 %0d", starts - s0, bus.overrun_count, exp_ovr);
    end
    bus.keycode = 8'd22;
    @(negedge CLK);
    bus.keycode = 8'd0;
    repeat (5) @(negedge CLK);
    total++;
    if (starts !== s0) begin
      bad++;
      $display("FAIL step_key_no_early_start: got starts=%0d want 0", starts - s0);
    end
    vs_fall();
    wait_start(got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL step_key_start: got %0b want 1", got);
    end
    finish_step(5);
    exp_steps++;
    vs_fall();
    repeat (8) @(negedge CLK);
    exp_ovr++;
    total++;
    if (starts - s0 !== 1 || bus.step_count !== 32'(exp_steps) || bus.overrun_count !== 16'(exp_ovr)) begin
      bad++;
      $display("FAIL step_key_once: got starts=%0d steps=%0d ovr=%0d want 1 %0d %0d",
        starts - s0, bus.step_count, bus.overrun_count, exp_steps, exp_ovr);
    end
    bus.keycode = 8'd44;
    @(negedge CLK);
    bus.keycode = 8'd0;
    @(negedge CLK);
    total++;
    if (bus.paused !== 1'b0) begin
      bad++;
      $display("FAIL pause_off: got %0b want 0", bus.paused);
    end
  endtask
  task automatic test_host;
    int s0;
    s0 = starts;
    bus.host_req = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.host_gnt !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL host_grant: got gnt=%0b busy=%0b want 1 0", bus.host_gnt, bus.busy);
    end
    vs_fall();
    repeat (8) @(negedge CLK);
    exp_ovr++;
    total++;
    if (starts !== s0 || bus.overrun_count !== 16'(exp_ovr) || bus.host_gnt !== 1'b1) begin
      bad++;
      $display("FAIL host_drop: got starts=%0d ovr=%0d gnt=%0b want 0 %0d 1",
        starts - s0, bus.overrun_count, bus.host_gnt, exp_ovr);
    end
    bus.host_req = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.host_gnt !== 1'b0) begin
      bad++;
      $display("FAIL host_release: got %0b want 0", bus.host_gnt);
    end
  endtask
  task automatic test_timeout;
    bit got;
    vs_fall();
    wait_start(got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL timeout_start: got %0b want 1", got);
    end
    repeat (64) @(negedge CLK);
    total++;
    if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got busy=%0b to=%0b want 1 0", bus.busy, bus.timeout_err);
    end
    @(negedge CLK);
    total++;
    if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1 || bus.step_count !== 32'(exp_steps)) begin
      bad++;
      $display("FAIL timeout_abort: got busy=%0b to=%0b steps=%0d want 0 1 %0d",
        bus.busy, bus.timeout_err, bus.step_count, exp_steps);
    end
    vs_fall();
    wait_start(got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL timeout_relaunch: got %0b want 1", got);
    end
    finish_step(4);
    exp_steps++;
    total++;
    if (bus.step_count !== 32'(exp_steps) || bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got steps=%0d to=%0b want %0d 1", bus.step_count, bus.timeout_err, exp_steps);
    end
  endtask
  task automatic test_stuck_done;
    bit got;
    int s0;
    int m0;
    bus.fsm_done = 1'b1;
    repeat (2) @(negedge CLK);
    s0 = starts;
    m0 = multi;
    vs_fall();
    wait_start(got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL stuck_start: got %0b want 1", got);
    end
    repeat (15) @(negedge CLK);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL stuck_wait: got busy=%0b want 1", bus.busy);
    end
    vs_fall();
    repeat (8) @(negedge CLK);
    exp_ovr++;
    total++;
    if (bus.overrun_count !== 16'(exp_ovr) || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL stuck_overrun: got ovr=%0d busy=%0b want %0d 1", bus.overrun_count, bus.busy, exp_ovr);
    end
    bus.fsm_done = 1'b0;
    @(negedge CLK);
    bus.fsm_done = 1'b1;
    repeat (2) @(negedge CLK);
    bus.fsm_done = 1'b0;
    exp_steps++;
    total++;
    if (bus.busy !== 1'b0 || bus.step_count !== 32'(exp_steps) || starts - s0 !== 1 || multi !== m0) begin
      bad++;
      $display("FAIL stuck_complete: got busy=%0b steps=%0d starts=%0d multi=%0d want 0 %0d 1 0",
        bus.busy, bus.step_count, starts - s0, multi - m0, exp_steps);
    end
  endtask
  task automatic test_reset_mid_step;
    bit got;
    vs_fall();
    wait_start(got);
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_start: got %0b want 1", got);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    total++;
    if ({bus.fsm_start, bus.host_gnt, bus.paused, bus.busy, bus.timeout_err, bus.step_count, bus.overrun_count} !== 53'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got st=%0b gnt=%0b p=%0b busy=%0b to=%0b steps=%0d ovr=%0d want all 0",
        bus.fsm_start, bus.host_gnt, bus.paused, bus.busy, bus.timeout_err, bus.step_count, bus.overrun_count);
    end
    bus.fsm_done = 1'b1;
    repeat (3) @(negedge CLK);
    bus.fsm_done = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.step_count !== 32'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_late_done: got steps=%0d busy=%0b want 0 0", bus.step_count, bus.busy);
    end
  endtask
  initial begin
    bus.VGA_VS = 1'b1;
    bus.keycode = 8'd0;
    bus.fsm_done = 1'b0;
    bus.host_req = 1'b0;
    test_reset();
    test_free_run();
    test_pause_step();
    test_host();
    test_timeout();
    test_stuck_done();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
